// File: rtl/seq_divider_if.sv
// Request/result bundle for the sequential divider.
// Handshake: start is honoured only at a rising edge where busy=0; done pulses for one cycle when results become valid.
interface seq_divider_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one shift-and-subtract step per clock,
// results held from done until the next completed operation.
module seq_divider #(
   parameter int WIDTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   seq_divider_if.slave bus,
   output logic [1:0]   o_dbg_state
);
   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_q;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_divisor;
   logic [WIDTH-1:0]   r_quot;
   logic [WIDTH-1:0]   r_remd;
   logic               r_dbz;

   logic               w_accept;
   logic               w_last;
   logic               w_zero_div;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_sub;
   logic               w_ge;
   logic [WIDTH-1:0]   w_rem_next;
   logic [WIDTH-1:0]   w_q_next;

   assign w_accept   = bus.start && (r_state != S_RUN);
   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_zero_div = (r_divisor == '0);

   // Partial remainder stays below the divisor, so a borrow out of the
   // WIDTH+1-bit subtraction is exactly "shifted value < divisor".
   assign w_shift    = {r_rem, r_q[WIDTH-1]};
   assign w_sub      = w_shift - {1'b0, r_divisor};
   assign w_ge       = ~w_sub[WIDTH];
   assign w_rem_next = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign w_q_next   = {r_q[WIDTH-2:0], w_ge};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) w_state_next = S_RUN;
         end
         S_RUN: begin
            bus.busy = 1'b1;
            if (w_zero_div || w_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            bus.done     = 1'b1;
            w_state_next = bus.start ? S_RUN : S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // A zero divisor spends one RUN cycle and then reports without iterating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_q       <= '0;
         r_rem     <= '0;
         r_divisor <= '0;
         r_quot    <= '0;
         r_remd    <= '0;
         r_dbz     <= 1'b0;
      end else if (w_accept) begin
         r_q       <= bus.dividend;
         r_divisor <= bus.divisor;
         r_rem     <= '0;
         r_cnt     <= '0;
      end else if (r_state == S_RUN) begin
         if (w_zero_div) begin
            r_quot <= '1;
            r_remd <= r_q;
            r_dbz  <= 1'b1;
         end else begin
            r_q   <= w_q_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
               r_quot <= w_q_next;
               r_remd <= w_rem_next;
               r_dbz  <= 1'b0;
            end
         end
      end
   end

   assign bus.quotient    = r_quot;
   assign bus.remainder   = r_remd;
   assign bus.div_by_zero = r_dbz;
   assign o_dbg_state     = r_state;
endmodule
